// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Stage indices, exception vector, ERET code and md handshake states.
package pipe_hazard_ctrl_pkg;

    localparam int STG_IF      = 0;
    localparam int STG_ID      = 1;
    localparam int STG_EX      = 2;
    localparam int STG_MEM     = 3;
    localparam int N_STAGE_DEF = 5;

    localparam logic [31:0] EXC_VEC_DEF = 32'hBFC00380;
    localparam logic [31:0] EXC_ERET    = 32'h0000000E;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md.sv
// Start/busy/cancel handshake towards the multi-cycle mult/div unit.
// The op sitting in EX is held until the unit reports a result.
module md_handshake_fsm
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic md_op,
    input  logic md_ready,
    input  logic acc,
    input  logic stall_fwd,
    output logic md_start,
    output logic md_cancel,
    output logic md_busy
);

    md_state_e state_q;
    md_state_e state_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        md_start  = 1'b0;
        md_cancel = 1'b0;
        md_busy   = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                // resetn gate keeps the start pulse quiet while reset is held
                if (resetn && md_op && !acc && !stall_fwd) begin
                    md_start = 1'b1;
                    md_busy  = 1'b1;
                    state_d  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (acc) begin
                    md_cancel = 1'b1;
                    state_d   = MD_IDLE;
                end else if (md_ready) begin
                    state_d = MD_DONE;
                end else begin
                    md_busy = 1'b1;
                end
            end
            MD_DONE: begin
                md_cancel = acc;
                state_d   = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the in-order pipeline: interlocks, md handshake
// and exception/ERET redirect with a registered target PC.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int          N_STAGE   = N_STAGE_DEF,
    parameter int          EX_STAGE  = STG_EX,
    parameter int          MEM_STAGE = STG_MEM,
    parameter int          LOAD_LAT  = 1,
    parameter int          REG_AW    = 5,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_STAGE-1:0] stall_req,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               id_branch_stall,
    input  logic               ex_rmem,
    input  logic [REG_AW-1:0]  ex_rt,
    input  logic               mem_rmem,
    input  logic [REG_AW-1:0]  mem_rt,
    input  logic               md_op,
    input  logic               md_ready,
    output logic               md_start,
    output logic               md_cancel,
    input  logic [31:0]        mem_excepttype,
    input  logic [31:0]        mem_cp0_epc,
    output logic [N_STAGE-1:0] stall,
    output logic [N_STAGE-1:0] flush,
    output logic               newpc_valid,
    output logic [31:0]        newpc
);

    logic               ex_hit;
    logic               mem_hit;
    logic               lu;
    logic               md_busy;
    logic               acc;
    logic               stall_mem_base;
    logic               stall_fwd;
    logic [N_STAGE-1:0] req_base;
    logic [N_STAGE-1:0] req;
    logic [N_STAGE-1:0] stall_c;
    logic [N_STAGE-1:0] bub_c;

    logic        newpc_valid_q;
    logic        newpc_valid_d;
    logic [31:0] newpc_q;
    logic [31:0] newpc_d;

    assign ex_hit = ex_rmem && (ex_rt != '0)
                    && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mem_hit = (LOAD_LAT == 2) && mem_rmem && (mem_rt != '0)
                     && ((mem_rt == id_rs) || (mem_rt == id_rt));
    assign lu = ex_hit || mem_hit;

    always_comb begin
        req_base         = stall_req;
        req_base[STG_ID] = stall_req[STG_ID] | lu | id_branch_stall;
    end

    always_comb begin
        req           = req_base;
        req[EX_STAGE] = req_base[EX_STAGE] | md_busy;
    end

    // Stages above EX never see md_busy, so these break the md/stall loop
    assign stall_mem_base = |req_base[N_STAGE-1:MEM_STAGE];
    assign stall_fwd      = |req_base[N_STAGE-1:EX_STAGE+1];

    assign acc = resetn && (mem_excepttype != '0) && !stall_mem_base;

    for (genvar j = 0; j < N_STAGE; j++) begin : g_stage
        assign stall_c[j] = |req[N_STAGE-1:j];
        if (j == 0) begin : g_if
            assign bub_c[j] = 1'b0;
        end else begin : g_up
            assign bub_c[j] = req[j-1] & ~stall_c[j];
        end
    end

    md_handshake_fsm u_md (
        .clk       (clk),
        .resetn    (resetn),
        .md_op     (md_op),
        .md_ready  (md_ready),
        .acc       (acc),
        .stall_fwd (stall_fwd),
        .md_start  (md_start),
        .md_cancel (md_cancel),
        .md_busy   (md_busy)
    );

    always_comb begin
        newpc_valid_d = acc;
        newpc_d       = newpc_q;
        if (acc) begin
            newpc_d = (mem_excepttype == EXC_ERET) ? mem_cp0_epc : EXC_VEC;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            newpc_valid_q <= 1'b0;
            newpc_q       <= '0;
        end else begin
            newpc_valid_q <= newpc_valid_d;
            newpc_q       <= newpc_d;
        end
    end

    always_comb begin
        stall = '0;
        flush = '1;
        if (resetn && !acc) begin
            stall         = stall_c;
            flush         = bub_c;
            flush[STG_IF] = bub_c[STG_IF] | newpc_valid_q;
        end
    end

    assign newpc_valid = newpc_valid_q;
    assign newpc       = newpc_q;

endmodule
